// File: rtl/muldiv_controller.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_controller
// Description : Iterative HI/LO multiply/divide unit (radix-2 shift-add multiply,
//               restoring divide); divider compiled in only with MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             e_start,
   input  logic [1:0]       e_op,
   input  logic [WIDTH-1:0] e_a,
   input  logic [WIDTH-1:0] e_b,
   input  logic             e_flush,
   input  logic             d_hilo_use,
   input  logic             w_hi_we,
   input  logic             w_lo_we,
   input  logic [WIDTH-1:0] w_wd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             hilo_stall,
   output logic             done
);

   localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
   localparam logic [1:0]      IDLE     = 2'd0;
   localparam logic [1:0]      CALC     = 2'd1;
   localparam logic [1:0]      FIX      = 2'd2;
   localparam logic [1:0]      DONE     = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_DIV_EN
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d;
   logic               bz_q, bz_d;
   logic [WIDTH:0]     div_shift, div_diff;

   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
`endif

   // Only the signed ops (op bit 0 clear) treat the MSB as a sign.
   assign sa    = ~e_op[0] & e_a[WIDTH-1];
   assign sb    = ~e_op[0] & e_b[WIDTH-1];
   assign mag_a = sa ? -e_a : e_a;
   assign mag_b = sb ? -e_b : e_b;

   assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_q ? -prod : prod;

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (is_div_q) begin
         res_lo = bz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
         res_hi = sa_q ? -acc_hi_q : acc_hi_q;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      b_d      = b_q;
      neg_d    = neg_q;
`ifdef MULDIV_DIV_EN
      is_div_d = is_div_q;
      sa_d     = sa_q;
      bz_d     = bz_q;
`endif
      case (state_q)
         IDLE: begin
            if (e_start && !e_flush) begin
               cnt_d    = CNT_LOAD;
               acc_hi_d = '0;
               neg_d    = sa ^ sb;
`ifdef MULDIV_DIV_EN
               state_d  = CALC;
               is_div_d = e_op[1];
               sa_d     = sa;
               bz_d     = (e_b == '0);
               acc_lo_d = e_op[1] ? mag_a : mag_b;
               b_d      = e_op[1] ? mag_b : mag_a;
`else
               state_d  = e_op[1] ? DONE : CALC;
               acc_lo_d = mag_b;
               b_d      = mag_a;
`endif
            end
         end
         CALC: begin
            // Multiplier bits leave acc_lo from the bottom as product bits enter the top.
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
               if (!div_diff[WIDTH]) begin
                  acc_hi_d = div_diff[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = div_shift[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end
`endif
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         b_q      <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULDIV_DIV_EN
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         bz_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
`ifdef MULDIV_DIV_EN
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         bz_q     <= bz_d;
`endif
         // A result commit takes priority over a coincident MTHI/MTLO.
         if (state_q == FIX) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end else begin
            if (w_hi_we) hi_q <= w_wd;
            if (w_lo_we) lo_q <= w_wd;
         end
      end
   end

   assign hi         = hi_q;
   assign lo         = lo_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign hilo_stall = busy & (d_hilo_use | e_start);

endmodule
`default_nettype wire
